// File: rtl/spi_target_regbridge_if.sv
// SPI pad and register-file bus bundle for spi_target_regbridge.
// master = SPI initiator / register file side, slave = bridge side.
interface spi_target_regbridge_if;
  logic       spi_sclk;
  logic       spi_csb;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oeb;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       frame_err;

  modport master (
    output spi_sclk, spi_csb, spi_mosi, reg_rdata,
    input  spi_miso, spi_miso_oeb, reg_addr, reg_wdata,
    input  reg_we, reg_re, busy, frame_err
  );

  modport slave (
    input  spi_sclk, spi_csb, spi_mosi, reg_rdata,
    output spi_miso, spi_miso_oeb, reg_addr, reg_wdata,
    output reg_we, reg_re, busy, frame_err
  );
endinterface

// File: rtl/spi_target_regbridge.sv
// SPI mode-0 target bridging a command byte plus data bytes
// onto a 7-bit address / 8-bit data register-file bus.
module spi_target_regbridge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  spi_target_regbridge_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sclk_sync, csb_sync, mosi_sync;
  logic sclk_q, csb_q;
  logic sclk_s, csb_s, mosi_s;
  logic sclk_rise, sclk_fall, csb_rise, csb_fall;
  logic rise, fall, byte_done;
  logic [7:0] byte_val;

  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic [7:0] tx;
  logic       is_read;
  logic       pend_re;
  logic       re_d1;
  logic       miso;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       we;
  logic       re;
  logic       ferr;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sclk_sync <= '0;
      csb_sync  <= '1;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      csb_q     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
      csb_sync  <= {csb_sync[SYNC_STAGES-2:0], bus.spi_csb};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
      sclk_q    <= sclk_s;
      csb_q     <= csb_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign csb_s     = csb_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign csb_rise  = csb_s & ~csb_q;
  assign csb_fall  = ~csb_s & csb_q;

  // csb deassertion masks any sclk edge seen in the same cycle
  assign rise      = (state != IDLE) & sclk_rise & ~csb_rise;
  assign fall      = (state != IDLE) & sclk_fall & ~csb_rise;
  assign byte_done = rise & (bit_cnt == 3'd7);
  assign byte_val  = {shreg, mosi_s};

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (csb_fall) state_n = CMD;
      CMD: begin
        if (csb_rise)       state_n = IDLE;
        else if (byte_done) state_n = DATA;
      end
      DATA: if (csb_rise) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      bit_cnt <= 3'd0;
      shreg   <= 7'd0;
      tx      <= 8'd0;
      is_read <= 1'b0;
      pend_re <= 1'b0;
      re_d1   <= 1'b0;
      miso    <= 1'b0;
      addr    <= 7'd0;
      wdata   <= 8'd0;
      we      <= 1'b0;
      re      <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      we      <= 1'b0;
      re      <= pend_re;
      pend_re <= 1'b0;
      re_d1   <= re;
      ferr    <= 1'b0;
      if (we)    addr <= addr + 7'd1;
      if (re_d1) tx   <= bus.reg_rdata;
      if (state == IDLE) begin
        miso <= 1'b0;
        if (csb_fall) begin
          bit_cnt <= 3'd0;
          is_read <= 1'b0;
        end
      end else if (csb_rise) begin
        ferr    <= (bit_cnt != 3'd0);
        re      <= 1'b0;
        pend_re <= 1'b0;
        miso    <= 1'b0;
      end else begin
        if (rise) begin
          shreg   <= byte_val[6:0];
          bit_cnt <= bit_cnt + 3'd1;
          // direction is known from the first command bit
          if (state == CMD && bit_cnt == 3'd0) is_read <= mosi_s;
          if (byte_done) begin
            if (state == CMD) begin
              addr    <= byte_val[6:0];
              is_read <= byte_val[7];
              re      <= byte_val[7];
            end else if (is_read) begin
              addr    <= addr + 7'd1;
              pend_re <= 1'b1;
            end else begin
              wdata <= byte_val;
              we    <= 1'b1;
            end
          end
        end
        if (fall && state == DATA && is_read) begin
          miso <= tx[7];
          tx   <= {tx[6:0], 1'b0};
        end
      end
    end
  end

  assign bus.spi_miso     = miso;
  assign bus.spi_miso_oeb = ~((state != IDLE) & is_read);
  assign bus.reg_addr     = addr;
  assign bus.reg_wdata    = wdata;
  assign bus.reg_we       = we;
  assign bus.reg_re       = re;
  assign bus.busy         = (state != IDLE);
  assign bus.frame_err    = ferr;

endmodule

// File: tb/tb_spi_target_regbridge.sv
// Scoreboard bench for spi_target_regbridge: SPI initiator driver,
// register-file responder, reference memory and output monitor.
module tb_spi_target_regbridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_target_regbridge_if bus ();

  spi_target_regbridge #(.SYNC_STAGES(2)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  int total = 0;
  int bad   = 0;
  int ph    = 5;

  logic [7:0]  ref_mem [128];
  logic [7:0]  dev_mem [128];
  logic [14:0] exp_wr [$];
  logic [6:0]  exp_re [$];
  logic [7:0]  exp_miso [$];
  logic [7:0]  got_miso [$];
  int          exp_err = 0;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endfunction

  function automatic void flag(string n);
    total++;
    bad++;
    $display("FAIL %s: event seen, none expected", n);
  endfunction

  always @(posedge clk) begin
    if (bus.reg_re) bus.reg_rdata <= dev_mem[bus.reg_addr];
    if (bus.reg_we) dev_mem[bus.reg_addr] = bus.reg_wdata;
  end

  logic [14:0] mw;
  logic [6:0]  mr;
  logic [7:0]  mg;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.reg_we && bus.reg_re) flag("we_and_re");
      if (bus.reg_we) begin
        if (exp_wr.size() == 0) flag("reg_we");
        else begin
          mw = exp_wr.pop_front();
          chk("we_addr", 32'(bus.reg_addr), 32'(mw[14:8]));
          chk("we_data", 32'(bus.reg_wdata), 32'(mw[7:0]));
        end
      end
      if (bus.reg_re) begin
        if (exp_re.size() == 0) flag("reg_re");
        else begin
          mr = exp_re.pop_front();
          chk("re_addr", 32'(bus.reg_addr), 32'(mr));
        end
      end
      if (bus.frame_err) begin
        if (exp_err == 0) flag("frame_err");
        else begin
          exp_err--;
          total++;
        end
      end
      if (got_miso.size() > 0) begin
        mg = got_miso.pop_front();
        if (exp_miso.size() == 0) flag("miso_byte");
        else chk("miso", 32'(mg), 32'(exp_miso.pop_front()));
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sbit(input logic b, output logic r);
    bus.spi_mosi = b;
    wait_clk(ph);
    r = bus.spi_miso;
    bus.spi_sclk = 1'b1;
    wait_clk(ph);
    bus.spi_sclk = 1'b0;
  endtask

  task automatic sbyte(input logic [7:0] b, output logic [7:0] r);
    logic t;
    for (int i = 7; i >= 0; i--) begin
      sbit(b[i], t);
      r[i] = t;
    end
  endtask

  task automatic check_reset();
    chk("rst_addr", 32'(bus.reg_addr), 0);
    chk("rst_wdata", 32'(bus.reg_wdata), 0);
    chk("rst_we", 32'(bus.reg_we), 0);
    chk("rst_re", 32'(bus.reg_re), 0);
    chk("rst_miso", 32'(bus.spi_miso), 0);
    chk("rst_oeb", 32'(bus.spi_miso_oeb), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_ferr", 32'(bus.frame_err), 0);
  endtask

  task automatic do_frame(input logic rd, input logic [6:0] a,
                          input logic [7:0] dq[$], input int partial);
    logic [7:0] r;
    logic [6:0] ad;
    logic t;
    ad = a;
    bus.spi_csb = 1'b0;
    wait_clk(ph);
    chk("busy_on", 32'(bus.busy), 1);
    if (rd) exp_re.push_back(a);
    exp_miso.push_back(8'h00);
    sbyte({rd, a}, r);
    got_miso.push_back(r);
    foreach (dq[k]) begin
      if (rd) begin
        exp_miso.push_back(ref_mem[ad]);
        exp_re.push_back(ad + 7'd1);
      end else begin
        exp_miso.push_back(8'h00);
        exp_wr.push_back({ad, dq[k]});
        ref_mem[ad] = dq[k];
      end
      sbyte(dq[k], r);
      got_miso.push_back(r);
      chk("oeb_frame", 32'(bus.spi_miso_oeb), rd ? 0 : 1);
      ad = ad + 7'd1;
    end
    if (partial > 0) begin
      exp_err++;
      for (int p = 0; p < partial; p++) sbit(1'($urandom), t);
    end
    wait_clk(ph);
    bus.spi_csb = 1'b1;
    wait_clk(10);
    chk("busy_off", 32'(bus.busy), 0);
    chk("oeb_idle", 32'(bus.spi_miso_oeb), 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] dq[$];
    logic [7:0] v;
    logic [7:0] r;
    logic t;
    bus.spi_sclk = 1'b0;
    bus.spi_csb  = 1'b1;
    bus.spi_mosi = 1'b0;
    for (int i = 0; i < 128; i++) begin
      v = 8'($urandom);
      ref_mem[i] = v;
      dev_mem[i] = v;
    end
    #1;
    check_reset();
    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);

    // single write
    dq = '{8'hA5};
    do_frame(1'b0, 7'h05, dq, 0);
    // burst write across the address wrap
    dq = '{8'h11, 8'h22};
    do_frame(1'b0, 7'h7F, dq, 0);
    // read with prefetch of 3, 4, 5
    ref_mem[3] = 8'h3C; dev_mem[3] = 8'h3C;
    ref_mem[4] = 8'hC5; dev_mem[4] = 8'hC5;
    dq = '{8'hFF, 8'h00};
    do_frame(1'b1, 7'h03, dq, 0);
    // aborted partial byte
    dq = '{};
    do_frame(1'b0, 7'h10, dq, 5);

    // reset during the 3rd data bit of a read
    ph = 5;
    bus.spi_csb = 1'b0;
    wait_clk(ph);
    exp_re.push_back(7'h20);
    sbyte(8'hA0, r);
    sbit(1'b0, t);
    sbit(1'b1, t);
    bus.spi_mosi = 1'b1;
    wait_clk(2);
    rst = 1'b1;
    #1;
    check_reset();
    bus.spi_csb  = 1'b1;
    bus.spi_sclk = 1'b0;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(6);
    dq = '{8'h5A};
    do_frame(1'b0, 7'h21, dq, 0);

    // csb rise coincident with the 8th data sclk rise
    bus.spi_csb = 1'b0;
    wait_clk(ph);
    sbyte(8'h30, r);
    for (int i = 0; i < 7; i++) sbit(1'b1, t);
    bus.spi_mosi = 1'b1;
    wait_clk(ph);
    exp_err++;
    bus.spi_sclk = 1'b1;
    bus.spi_csb  = 1'b1;
    wait_clk(8);
    bus.spi_sclk = 1'b0;
    wait_clk(4);
    chk("busy_coinc", 32'(bus.busy), 0);

    // randomized frames
    for (int f = 0; f < 24; f++) begin
      int nb;
      logic rd;
      logic [6:0] a;
      ph = $urandom_range(4, 7);
      rd = 1'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(125, 127))
                                       : 7'($urandom);
      nb = $urandom_range(0, 3);
      dq = '{};
      for (int k = 0; k < nb; k++) dq.push_back(8'($urandom));
      do_frame(rd, a, dq, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0);
    end

    wait_clk(10);
    chk("left_wr", exp_wr.size(), 0);
    chk("left_re", exp_re.size(), 0);
    chk("left_miso", exp_miso.size(), 0);
    chk("left_err", 32'(exp_err), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
